// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot-time ROM loader: FSM state encodings,
// error codes and the frame length width.
package rom_loader_pkg;

    // Frame length field is a 16-bit big-endian word count.
    localparam int LEN_W = 16;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_HI = 3'd1,
        LDR_LEN_LO = 3'd2,
        LDR_BYTE   = 3'd3,
        LDR_WRITE  = 3'd4,
        LDR_CHK    = 3'd5,
        LDR_DONE   = 3'd6,
        LDR_ERR    = 3'd7
    } ldr_state_t;

    localparam logic [1:0] LDR_ERR_NONE    = 2'd0;
    localparam logic [1:0] LDR_ERR_LEN     = 2'd1;
    localparam logic [1:0] LDR_ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] LDR_ERR_CSUM    = 2'd3;

endpackage

// File: rtl/rom_loader_timeout.sv
// Idle-cycle watchdog for the loader. Counts consecutive enabled cycles
// without a byte transfer; expire_o flags the cycle on which the count
// reaches TIMEOUT_CYC. Leaving the enabled states or a transfer clears it.
module rom_loader_timeout #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    // Count idle cycles while enabled; any transfer or disable restarts from zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i || !en_i) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // This idle cycle is the TIMEOUT_CYC-th in a row.
    assign expire_o = en_i && !clr_i && (cnt == LAST);

endmodule

// File: rtl/rom_loader.sv
// Boot-time instruction ROM loader. Receives a framed byte stream
// (LEN_HI, LEN_LO, then N big-endian 32-bit words), issues one-cycle ROM
// write strobes, and stalls the CPU until the image is loaded.
// Optional trailing XOR checksum byte: define ROM_LOADER_CHECKSUM_EN.
//
// Byte handshake: rx_ready_o is registered and high only in LEN_HI,
// LEN_LO, BYTE and CHK; a byte transfers on a clk_i edge where
// rx_valid_i && rx_ready_o, and the host may hold rx_valid_i high.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int MAX_WORDS   = 1024,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [31:0]       w_rom_data,
    output logic [ADDR_W-1:0] w_rom_addr,
    output logic              en_w_rom,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [1:0]        err_code_o,
    output ldr_state_t        dbg_state_o
);

    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

    ldr_state_t       state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] word_idx;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    logic             xfer;
    logic             tmo_expire;
    logic [LEN_W-1:0] idx_nxt;
    logic [LEN_W-1:0] full_len;

    assign xfer        = rx_valid_i && rx_ready_o;
    assign idx_nxt     = word_idx + LEN_W'(1);
    assign full_len    = {len_hi, rx_data_i};
    assign dbg_state_o = state;

    rom_loader_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (rx_ready_o),
        .clr_i    (xfer),
        .expire_o (tmo_expire)
    );

    // Loader FSM with registered handshake, write-port and status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= LDR_IDLE;
            rx_ready_o  <= 1'b0;
            en_w_rom    <= 1'b0;
            w_rom_data  <= '0;
            w_rom_addr  <= '0;
            cpu_hold_o  <= 1'b0;
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            err_code_o  <= LDR_ERR_NONE;
            len_hi      <= '0;
            len         <= '0;
            word_idx    <= '0;
            byte_cnt    <= '0;
            asm_q       <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            en_w_rom <= 1'b0;
            case (state)
                LDR_IDLE: begin
                    rx_ready_o <= 1'b0;
                    if (start_i) begin
                        state       <= LDR_LEN_HI;
                        rx_ready_o  <= 1'b1;
                        cpu_hold_o  <= 1'b1;
                        load_done_o <= 1'b0;
                        load_err_o  <= 1'b0;
                        err_code_o  <= LDR_ERR_NONE;
                        word_idx    <= '0;
                        byte_cnt    <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum        <= '0;
`endif
                    end
                end
                LDR_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= rx_data_i;
                        state  <= LDR_LEN_LO;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum   <= csum ^ rx_data_i;
`endif
                    end else if (tmo_expire) begin
                        state      <= LDR_ERR;
                        rx_ready_o <= 1'b0;
                        load_err_o <= 1'b1;
                        err_code_o <= LDR_ERR_TIMEOUT;
                    end
                end
                LDR_LEN_LO: begin
                    if (xfer) begin
                        len <= full_len;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data_i;
`endif
                        if (full_len == '0) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                            state <= LDR_CHK;
`else
                            state       <= LDR_DONE;
                            rx_ready_o  <= 1'b0;
                            cpu_hold_o  <= 1'b0;
                            load_done_o <= 1'b1;
`endif
                        end else if ({1'b0, full_len} > MAX_LEN) begin
                            state      <= LDR_ERR;
                            rx_ready_o <= 1'b0;
                            load_err_o <= 1'b1;
                            err_code_o <= LDR_ERR_LEN;
                        end else begin
                            state    <= LDR_BYTE;
                            byte_cnt <= '0;
                        end
                    end else if (tmo_expire) begin
                        state      <= LDR_ERR;
                        rx_ready_o <= 1'b0;
                        load_err_o <= 1'b1;
                        err_code_o <= LDR_ERR_TIMEOUT;
                    end
                end
                LDR_BYTE: begin
                    if (xfer) begin
                        asm_q    <= {asm_q[15:0], rx_data_i};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef ROM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data_i;
`endif
                        // Fourth byte: strobe the word out next cycle.
                        if (byte_cnt == 2'd3) begin
                            state      <= LDR_WRITE;
                            rx_ready_o <= 1'b0;
                            en_w_rom   <= 1'b1;
                            w_rom_data <= {asm_q, rx_data_i};
                            w_rom_addr <= ADDR_W'(word_idx);
                        end
                    end else if (tmo_expire) begin
                        state      <= LDR_ERR;
                        rx_ready_o <= 1'b0;
                        load_err_o <= 1'b1;
                        err_code_o <= LDR_ERR_TIMEOUT;
                    end
                end
                LDR_WRITE: begin
                    word_idx <= idx_nxt;
                    if (idx_nxt == len) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                        state      <= LDR_CHK;
                        rx_ready_o <= 1'b1;
`else
                        state       <= LDR_DONE;
                        cpu_hold_o  <= 1'b0;
                        load_done_o <= 1'b1;
`endif
                    end else begin
                        state      <= LDR_BYTE;
                        rx_ready_o <= 1'b1;
                        byte_cnt   <= '0;
                    end
                end
                LDR_CHK: begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    if (xfer) begin
                        rx_ready_o <= 1'b0;
                        if ((csum ^ rx_data_i) == 8'h00) begin
                            state       <= LDR_DONE;
                            cpu_hold_o  <= 1'b0;
                            load_done_o <= 1'b1;
                        end else begin
                            state      <= LDR_ERR;
                            load_err_o <= 1'b1;
                            err_code_o <= LDR_ERR_CSUM;
                        end
                    end else if (tmo_expire) begin
                        state      <= LDR_ERR;
                        rx_ready_o <= 1'b0;
                        load_err_o <= 1'b1;
                        err_code_o <= LDR_ERR_TIMEOUT;
                    end
`else
                    state      <= LDR_IDLE;
                    rx_ready_o <= 1'b0;
`endif
                end
                LDR_DONE: begin
                    state <= LDR_IDLE;
                end
                LDR_ERR: begin
                    state <= LDR_IDLE;
                end
                default: begin
                    state      <= LDR_IDLE;
                    rx_ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table of frames plus hand-written
// sequences for latency, timeout, length boundary, reset and checksum.
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam int ADDR_W      = 16;
    localparam int MAX_WORDS   = 1024;
    localparam int TIMEOUT_CYC = 16;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [7:0]        rx_data_i = 8'h00;
    logic              rx_valid_i = 1'b0;
    logic              rx_ready_o;
    logic [31:0]       w_rom_data;
    logic [ADDR_W-1:0] w_rom_addr;
    logic              en_w_rom;
    logic              cpu_hold_o;
    logic              load_done_o;
    logic              load_err_o;
    logic [1:0]        err_code_o;
    ldr_state_t        dbg_state_o;

    rom_loader #(
        .ADDR_W      (ADDR_W),
        .MAX_WORDS   (MAX_WORDS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .rx_ready_o  (rx_ready_o),
        .w_rom_data  (w_rom_data),
        .w_rom_addr  (w_rom_addr),
        .en_w_rom    (en_w_rom),
        .cpu_hold_o  (cpu_hold_o),
        .load_done_o (load_done_o),
        .load_err_o  (load_err_o),
        .err_code_o  (err_code_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock and watchdog.
    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected ROM writes as {addr, data}.
    logic [47:0] exp_q[$];
    int          wr_cnt = 0;
    logic        prev_en = 1'b0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (en_w_rom) begin
            wr_cnt++;
            check("en_w_rom_one_cycle", 48'(prev_en), 48'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         w_rom_addr, w_rom_data);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                check("rom_write", {w_rom_addr, w_rom_data}, e);
            end
        end
        prev_en = en_w_rom;
    end

    // Driver tasks. Inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        while (!rx_ready_o && n < 100) begin
            tick();
            n++;
        end
        if (!rx_ready_o) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: got ready=0 for 100 cycles expected 1");
        end else begin
            tick();
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        start_i    = 1'b0;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(load_done_o || load_err_o) && n < 200) begin
            tick();
            n++;
        end
        if (!(load_done_o || load_err_o)) begin
            checks++;
            errors++;
            $display("FAIL wait_end: got no done/err in 200 cycles expected one");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 48'({rx_ready_o, en_w_rom, cpu_hold_o, load_done_o,
                                   load_err_o, err_code_o}), 48'd0);
        check({tag, "_data"}, 48'(w_rom_data), 48'd0);
        check({tag, "_addr"}, 48'(w_rom_addr), 48'd0);
        check({tag, "_state"}, 48'(dbg_state_o), 48'(LDR_IDLE));
    endtask

    typedef struct {
        logic [15:0]      len;
        int               n_words;
        logic [2:0][31:0] words;
        bit               exp_done;
        bit               exp_err;
        logic [1:0]       exp_code;
        bit               exp_hold;
    } vec_t;

    task automatic send_frame(input vec_t v, input bit with_csum);
        logic [7:0] x;
        x = v.len[15:8] ^ v.len[7:0];
        send_byte(v.len[15:8]);
        send_byte(v.len[7:0]);
        for (int w = 0; w < v.n_words; w++) begin
            for (int b = 3; b >= 0; b--) begin
                x = x ^ v.words[w][8*b +: 8];
                send_byte(v.words[w][8*b +: 8]);
            end
        end
        if (with_csum) begin
`ifdef ROM_LOADER_CHECKSUM_EN
            send_byte(x);
`endif
        end
        rx_valid_i = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{len: 16'h0002, n_words: 2, words: '0, exp_done: 1, exp_err: 0, exp_code: 2'd0, exp_hold: 0};
        vecs[0].words[0] = 32'hDEADBEEF;
        vecs[0].words[1] = 32'h12345678;
        vecs[1] = '{len: 16'h0000, n_words: 0, words: '0, exp_done: 1, exp_err: 0, exp_code: 2'd0, exp_hold: 0};
        vecs[2] = '{len: 16'h0401, n_words: 0, words: '0, exp_done: 0, exp_err: 1, exp_code: 2'd1, exp_hold: 1};
        vecs[3] = '{len: 16'h0001, n_words: 1, words: '0, exp_done: 1, exp_err: 0, exp_code: 2'd0, exp_hold: 0};
        vecs[3].words[0] = 32'h00000005;
        vecs[4] = '{len: 16'hFFFF, n_words: 0, words: '0, exp_done: 0, exp_err: 1, exp_code: 2'd1, exp_hold: 1};
        vecs[5] = '{len: 16'h0003, n_words: 3, words: '0, exp_done: 1, exp_err: 0, exp_code: 2'd0, exp_hold: 0};
        vecs[5].words[0] = 32'hA5A5A5A5;
        vecs[5].words[1] = 32'h0000FFFF;
        vecs[5].words[2] = 32'h80000001;

        // Reset.
        repeat (3) @(posedge clk_i);
        #1;
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();

        // Table-driven frames.
        for (int i = 0; i < 6; i++) begin
            wr_cnt = 0;
            if (vecs[i].exp_done) begin
                for (int w = 0; w < vecs[i].n_words; w++)
                    exp_q.push_back({16'(w), vecs[i].words[w]});
            end
            do_start();
            send_frame(vecs[i], vecs[i].exp_done);
            wait_end();
            check($sformatf("vec%0d_done", i), 48'(load_done_o), 48'(vecs[i].exp_done));
            check($sformatf("vec%0d_err", i), 48'(load_err_o), 48'(vecs[i].exp_err));
            check($sformatf("vec%0d_code", i), 48'(err_code_o), 48'(vecs[i].exp_code));
            check($sformatf("vec%0d_hold", i), 48'(cpu_hold_o), 48'(vecs[i].exp_hold));
            check($sformatf("vec%0d_writes", i), 48'(wr_cnt),
                  48'(vecs[i].exp_done ? vecs[i].n_words : 0));
            check($sformatf("vec%0d_pending", i), 48'(exp_q.size()), 48'd0);
            exp_q.delete();
            tick();
            tick();
        end

        // Zero-length frame completes within 4 cycles of start.
        do_start();
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        rx_valid_i = 1'b0;
        check("zero_len_done_fast", 48'(load_done_o), 48'd1);
        tick();
        tick();

        // Strobe latency, data hold and hold release after the last write.
        wr_cnt = 0;
        exp_q.push_back({16'h0000, 32'hCAFEF00D});
        do_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        send_byte(8'h0D);
        rx_valid_i = 1'b0;
        check("strobe_latency", 48'({en_w_rom, cpu_hold_o}), 48'b11);
        check("strobe_word", {w_rom_addr, w_rom_data}, {16'h0000, 32'hCAFEF00D});
        tick();
        check("strobe_ends", 48'(en_w_rom), 48'd0);
        check("data_holds", {w_rom_addr, w_rom_data}, {16'h0000, 32'hCAFEF00D});
`ifdef ROM_LOADER_CHECKSUM_EN
        check("hold_in_chk", 48'(cpu_hold_o), 48'd1);
        send_byte(8'hC8);
        rx_valid_i = 1'b0;
`else
        check("hold_falls_after_write", 48'({cpu_hold_o, load_done_o}), 48'b01);
`endif
        wait_end();
        check("latency_frame_done", 48'({load_done_o, load_err_o}), 48'b10);
        check("latency_frame_writes", 48'(wr_cnt), 48'd1);
        tick();
        tick();

        // rx_valid_i in IDLE is not consumed.
        rx_data_i  = 8'h55;
        rx_valid_i = 1'b1;
        tick();
        tick();
        tick();
        check("idle_not_ready", 48'({rx_ready_o, 1'b0, dbg_state_o}), 48'({1'b0, 1'b0, LDR_IDLE}));
        rx_valid_i = 1'b0;

        // Timeout mid-word: partial word must not be written.
        wr_cnt = 0;
        do_start();
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'hDE);
        send_byte(8'hAD);
        rx_valid_i = 1'b0;
        repeat (10) tick();
        check("timeout_not_early", 48'(load_err_o), 48'd0);
        wait_end();
        check("timeout_flags", 48'({load_done_o, load_err_o, err_code_o, cpu_hold_o}),
              48'({1'b0, 1'b1, 2'd2, 1'b1}));
        check("timeout_no_write", 48'(wr_cnt), 48'd0);
        tick();
        tick();

        // Length exactly MAX_WORDS is accepted.
        do_start();
        send_byte(8'h04);
        send_byte(8'h00);
        rx_valid_i = 1'b0;
        check("max_len_accepted", 48'({load_err_o, dbg_state_o}), 48'({1'b0, LDR_BYTE}));
        do_reset();

        // Reset after 3 words of an 8-word load, with start_i held mid-frame.
        wr_cnt = 0;
        exp_q.push_back({16'h0000, 32'h11111111});
        exp_q.push_back({16'h0001, 32'h22222222});
        exp_q.push_back({16'h0002, 32'h33333333});
        do_start();
        start_i = 1'b1;
        send_byte(8'h00);
        send_byte(8'h08);
        for (int w = 1; w <= 3; w++) begin
            for (int b = 0; b < 4; b++) send_byte({w[3:0], w[3:0]});
        end
        start_i    = 1'b0;
        rx_valid_i = 1'b0;
        tick();
        check("midload_writes", 48'(wr_cnt), 48'd3);
        check("midload_hold", 48'({cpu_hold_o, load_done_o}), 48'b10);
        do_reset();
        check_reset_outputs("midload_reset");
        wr_cnt = 0;
        exp_q.push_back({16'h0000, 32'h0BADCAFE});
        vecs[0] = '{len: 16'h0001, n_words: 1, words: '0, exp_done: 1, exp_err: 0, exp_code: 2'd0, exp_hold: 0};
        vecs[0].words[0] = 32'h0BADCAFE;
        do_start();
        send_frame(vecs[0], 1'b1);
        wait_end();
        check("reload_done", 48'({load_done_o, cpu_hold_o}), 48'b10);
        check("reload_writes", 48'(wr_cnt), 48'd1);
        tick();
        tick();

`ifdef ROM_LOADER_CHECKSUM_EN
        // Checksum good and bad trailers.
        for (int t = 0; t < 2; t++) begin
            wr_cnt = 0;
            exp_q.push_back({16'h0000, 32'h00000005});
            do_start();
            send_byte(8'h00);
            send_byte(8'h01);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'h05);
            send_byte(t == 0 ? 8'h04 : 8'h05);
            rx_valid_i = 1'b0;
            wait_end();
            if (t == 0)
                check("csum_good", 48'({load_done_o, load_err_o, err_code_o, cpu_hold_o}),
                      48'({1'b1, 1'b0, 2'd0, 1'b0}));
            else
                check("csum_bad", 48'({load_done_o, load_err_o, err_code_o, cpu_hold_o}),
                      48'({1'b0, 1'b1, 2'd3, 1'b1}));
            check("csum_writes", 48'(wr_cnt), 48'd1);
            tick();
            tick();
        end
`endif

        check("final_pending", 48'(exp_q.size()), 48'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
